reset_seq_gen: RTL

//  Parametrised successor to the chip clock/reset generator. Pulses the clock manager (DCM) reset and waits for a stable lock.

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/sync_debounce.sv | 55 +++++
 rtl/reset_seq_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
// Holds the FSM state encoding, the board-level reset/enable polarity
// constants and a small constant helper used when sizing counters.
package rst_seq_pkg;

    // Polarity constants as used by the global headers
    localparam logic RESET_ENABLE = 1'b0;   // level that holds a block in reset
    localparam logic ENABLE       = 1'b1;   // level that asserts an active-high control

    typedef enum logic [2:0] {
        DCM_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SW_HOLD   = 3'd4,
        HALT      = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability filter.
// The filtered level only follows the synchronised input after that input
// has differed from the current filtered level for DEB_CYC consecutive cycles.
// Ports:
//   clk    in  1  sampling clock
//   rst_n  in  1  async active-low reset
//   raw    in  1  asynchronous input
//   level  out 1  synchronised, debounced level (resets to RST_VAL)
module sync_debounce #(
    parameter int   DEB_CYC = 16,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    // Counter only ever holds 0..DEB_CYC-1
    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          meta_r;
    logic          sync_r;
    logic          level_r;
    logic [CW-1:0] stab_cnt_r;

    // Two-flop synchroniser for the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
        end
    end

    // Accept a new level after DEB_CYC consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r    <= RST_VAL;
            stab_cnt_r <= {CW{1'b0}};
        end else if (sync_r == level_r) begin
            stab_cnt_r <= {CW{1'b0}};
        end else if (stab_cnt_r == CW'(DEB_CYC - 1)) begin
            level_r    <= sync_r;
            stab_cnt_r <= {CW{1'b0}};
        end else begin
            stab_cnt_r <= stab_cnt_r + CW'(1);
        end
    end

    assign level = level_r;

endmodule

// File: rtl/reset_seq_gen.sv
// Chip reset sequencer between the DCM and all core/bus/IO reset inputs.
// Pulses the DCM reset, waits for a stable lock (retrying on timeout),
// then releases NUM_DOM reset domains one at a time, STAGE_GAP cycles apart.
// Lock loss or a debounced switch press puts every domain back in reset
// on the same clock edge. All outputs come straight from flops.
// Ports:
//   clk        in  1        free-running reference clock
//   reset      in  1        async active-low power-on reset
//   reset_sw   in  1        raw push-button, active-low, async
//   locked     in  1        DCM lock, async
//   dcm_reset  out 1        DCM reset, active-high
//   dom_reset  out NUM_DOM  per-domain reset, active-low, domain 0 first
//   ready      out 1        all domains released
//   retry_cnt  out 3        failed lock attempts since last good lock
//   lock_err   out 1        sticky lock failure flag
module reset_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM      = 3,
    parameter int DEB_CYC      = 16,
    parameter int DCM_RST_CYC  = 4,
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 64,
    parameter int STAGE_GAP    = 4,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reset_sw,
    input  logic               locked,
    output logic               dcm_reset,
    output logic [NUM_DOM-1:0] dom_reset,
    output logic               ready,
    output logic [2:0]         retry_cnt,
    output logic               lock_err
);

    // One timer serves DCM_RST, WAIT_LOCK timeout and RELEASE spacing
    localparam int TMR_MAX = max_int(max_int(DCM_RST_CYC, LOCK_TIMEOUT), STAGE_GAP);
    localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int LW      = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [TW-1:0]        tmr_cnt_r;
    logic [TW-1:0]        tmr_nxt_s;
    logic [LW-1:0]        lock_cnt_r;
    logic [LW-1:0]        lock_nxt_s;
    logic [2:0]           retry_cnt_r;
    logic [2:0]           retry_nxt_s;
    logic                 lock_err_r;
    logic                 err_nxt_s;
    logic [NUM_DOM-1:0]   dom_reset_r;
    logic [NUM_DOM-1:0]   dom_nxt_s;
    logic [NUM_DOM-1:0]   dom_load_s;
    logic                 dcm_reset_r;
    logic                 ready_r;
    logic                 lock_meta_r;
    logic                 locked_sync_r;
    logic                 sw_db_s;

    sync_debounce #(
        .DEB_CYC (DEB_CYC),
        .RST_VAL (1'b1)
    ) u_sw_deb (
        .clk   (clk),
        .rst_n (reset),
        .raw   (reset_sw),
        .level (sw_db_s)
    );

    // Plain two-flop synchroniser for the DCM lock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_meta_r   <= 1'b0;
            locked_sync_r <= 1'b0;
        end else begin
            lock_meta_r   <= locked;
            locked_sync_r <= lock_meta_r;
        end
    end

    // Next-state, timers and retry bookkeeping; switch press outranks lock loss
    always_comb begin
        state_nxt_s = state_r;
        tmr_nxt_s   = tmr_cnt_r + TW'(1);
        lock_nxt_s  = {LW{1'b0}};
        retry_nxt_s = retry_cnt_r;
        err_nxt_s   = lock_err_r;
        dom_nxt_s   = dom_reset_r;
        if (!sw_db_s && (state_r != SW_HOLD)) begin
            state_nxt_s = SW_HOLD;
            if (state_r == HALT) begin
                retry_nxt_s = 3'd0;
                err_nxt_s   = 1'b0;
            end else begin
                retry_nxt_s = retry_cnt_r;
            end
        end else begin
            case (state_r)
                DCM_RST: begin
                    if (tmr_cnt_r == TW'(DCM_RST_CYC - 1)) begin
                        state_nxt_s = WAIT_LOCK;
                    end else begin
                        state_nxt_s = DCM_RST;
                    end
                end
                WAIT_LOCK: begin
                    lock_nxt_s = locked_sync_r ? (lock_cnt_r + LW'(1)) : {LW{1'b0}};
                    if (locked_sync_r && (lock_cnt_r == LW'(LOCK_STABLE - 1))) begin
                        state_nxt_s = RELEASE;
                        retry_nxt_s = 3'd0;
                    end else if (tmr_cnt_r == TW'(LOCK_TIMEOUT - 1)) begin
                        if (retry_cnt_r == 3'(MAX_RETRY)) begin
                            state_nxt_s = HALT;
                            err_nxt_s   = 1'b1;
                        end else begin
                            state_nxt_s = DCM_RST;
                            retry_nxt_s = (retry_cnt_r == 3'd7) ? 3'd7 : (retry_cnt_r + 3'd1);
                        end
                    end else begin
                        state_nxt_s = WAIT_LOCK;
                    end
                end
                RELEASE: begin
                    // Abort on lock loss is not a failed attempt: retry_cnt untouched
                    if (!locked_sync_r) begin
                        state_nxt_s = DCM_RST;
                    end else if (dom_reset_r[NUM_DOM-1]) begin
                        state_nxt_s = RUN;
                    end else if (tmr_cnt_r == TW'(STAGE_GAP - 1)) begin
                        dom_nxt_s = (dom_reset_r << 1) | NUM_DOM'(1'b1);
                        tmr_nxt_s = {TW{1'b0}};
                    end else begin
                        state_nxt_s = RELEASE;
                    end
                end
                RUN: begin
                    if (!locked_sync_r) begin
                        state_nxt_s = DCM_RST;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                SW_HOLD: begin
                    if (sw_db_s) begin
                        state_nxt_s = DCM_RST;
                    end else begin
                        state_nxt_s = SW_HOLD;
                    end
                end
                HALT: begin
                    state_nxt_s = HALT;
                end
                default: begin
                    state_nxt_s = DCM_RST;
                end
            endcase
        end
    end

    // Domain vector: seed domain 0 on RELEASE entry, drop all on any exit
    always_comb begin
        if ((state_nxt_s == RELEASE) && (state_r != RELEASE)) begin
            dom_load_s = NUM_DOM'(1'b1);
        end else if ((state_nxt_s == RELEASE) || (state_nxt_s == RUN)) begin
            dom_load_s = dom_nxt_s;
        end else begin
            dom_load_s = {NUM_DOM{RESET_ENABLE}};
        end
    end

    // State, counters and registered outputs; counters reload on every state entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= DCM_RST;
            tmr_cnt_r   <= {TW{1'b0}};
            lock_cnt_r  <= {LW{1'b0}};
            retry_cnt_r <= 3'd0;
            lock_err_r  <= 1'b0;
            dom_reset_r <= {NUM_DOM{RESET_ENABLE}};
            dcm_reset_r <= ENABLE;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            retry_cnt_r <= retry_nxt_s;
            lock_err_r  <= err_nxt_s;
            dom_reset_r <= dom_load_s;
            dcm_reset_r <= ((state_nxt_s == DCM_RST) || (state_nxt_s == SW_HOLD)) ? ENABLE : ~ENABLE;
            ready_r     <= (state_nxt_s == RUN);
            if (state_nxt_s != state_r) begin
                tmr_cnt_r  <= {TW{1'b0}};
                lock_cnt_r <= {LW{1'b0}};
            end else begin
                tmr_cnt_r  <= tmr_nxt_s;
                lock_cnt_r <= lock_nxt_s;
            end
        end
    end

    assign dcm_reset = dcm_reset_r;
    assign dom_reset = dom_reset_r;
    assign ready     = ready_r;
    assign retry_cnt = retry_cnt_r;
    assign lock_err  = lock_err_r;

endmodule
